// File: rtl/pearson_hash_nbyte_pkg.sv
// Shared types and the Pearson permutation for the multi-lane hasher.
// The optional message-length output is enabled with PEARSON_MSG_LEN_EN.
package pearson_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [0:0] {
    START  = 1'b0,
    ABSORB = 1'b1
  } state_t;

  // T[x] = (167*x + 13) mod 256; 167 is odd, so this is a bijection on bytes.
  function automatic byte_t pearson_t(input byte_t x);
    logic [15:0] p;
    p = 16'(x) * 16'd167 + 16'd13;
    return p[7:0];
  endfunction

endpackage

// File: rtl/pearson_hash_nbyte_if.sv
// Byte-in / hash-out stream bundle. Both sides use valid/ready: a transfer
// happens on a rising edge where valid and ready are both high.
interface pearson_hash_nbyte_if #(
  parameter int HASH_BYTES = 4,
  parameter int LEN_W      = 16
);
  import pearson_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  byte_t                   in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [8*HASH_BYTES-1:0] out_hash;
`ifdef PEARSON_MSG_LEN_EN
  logic [LEN_W-1:0]        out_len;
`endif

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_hash
`ifdef PEARSON_MSG_LEN_EN
    , output out_len
`endif
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_hash
`ifdef PEARSON_MSG_LEN_EN
    , input out_len
`endif
  );

endinterface

// File: rtl/pearson_hash_nbyte_lane.sv
// One 8-bit Pearson lane: register, seed/feedback select and table lookup.
// h_next is the value the lane takes if the current byte is accepted.
module pearson_lane
  import pearson_pkg::*;
#(
  parameter byte_t SEED = 8'h00
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  load,
  input  logic  first,
  input  byte_t c,
  output byte_t h_next
);

  byte_t h;

  assign h_next = pearson_t((first ? SEED : h) ^ c);

  always_ff @(posedge clock) begin
    if (reset) begin
      h <= '0;
    end else if (load) begin
      h <= h_next;
    end
  end

endmodule

// File: rtl/pearson_hash_nbyte.sv
// HASH_BYTES-lane Pearson hasher, one byte per cycle, registered hash output.
// Define PEARSON_MSG_LEN_EN to add a saturating message-length output.
module pearson_hash_nbyte
  import pearson_pkg::*;
#(
  parameter int HASH_BYTES = 4,
  parameter int LEN_W      = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   init,
  pearson_hash_nbyte_if.slave    bus,
  output state_t                 state_dbg
);

  localparam logic [0:0] S_START  = 1'b0;
  localparam logic [0:0] S_ABSORB = 1'b1;
  localparam int         W        = 8 * HASH_BYTES;

  logic [0:0]   state_q;
  logic         accept;
  logic         first;
  logic [W-1:0] hash_next;

  assign bus.in_ready = enable & ~reset & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  // An init coinciding with an accepted byte restarts the message on that byte.
  assign first        = (state_q == S_START) | init;
  assign state_dbg    = state_t'(state_q);

  for (genvar j = 0; j < HASH_BYTES; j++) begin : g_lane
    pearson_lane #(.SEED(byte_t'(j))) u_lane (
      .clock  (clock),
      .reset  (reset),
      .load   (accept),
      .first  (first),
      .c      (bus.in_data),
      .h_next (hash_next[8*j +: 8])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_START;
    end else if (accept) begin
      state_q <= bus.in_last ? S_START : S_ABSORB;
    end else if (enable && init) begin
      state_q <= S_START;
    end
  end

  // A held output is only released by a consumer transfer while enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_hash  <= '0;
    end else if (accept && bus.in_last) begin
      bus.out_valid <= 1'b1;
      bus.out_hash  <= hash_next;
    end else if (enable && bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef PEARSON_MSG_LEN_EN
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_next;

  always_comb begin
    len_next = len_q;
    if (first) begin
      len_next = LEN_W'(1);
    end else if (!(&len_q)) begin
      len_next = len_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      len_q       <= '0;
      bus.out_len <= '0;
    end else begin
      if (accept) begin
        len_q <= len_next;
      end else if (enable && init) begin
        len_q <= '0;
      end
      if (accept && bus.in_last) begin
        bus.out_len <= len_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pearson_hash_nbyte.sv
// Self-checking bench for pearson_hash_nbyte (4-lane and 1-lane instances)
// against a message-level Pearson reference model.
module tb_pearson_hash_nbyte;
  import pearson_pkg::*;

  localparam int HB    = 4;
  localparam int LW    = 16;
  localparam int W     = 8 * HB;
  localparam logic [31:0] H_ZERO = 32'h025BB40D;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic init;
  logic enable1;
  logic init1;
  state_t state_dbg;
  state_t state_dbg1;

  always #5 clock = ~clock;

  pearson_hash_nbyte_if #(.HASH_BYTES(HB), .LEN_W(LW)) bus ();
  pearson_hash_nbyte_if #(.HASH_BYTES(1),  .LEN_W(LW)) bus1 ();

  pearson_hash_nbyte #(.HASH_BYTES(HB), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .init(init),
    .bus(bus), .state_dbg(state_dbg)
  );

  pearson_hash_nbyte #(.HASH_BYTES(1), .LEN_W(LW)) dut1 (
    .clock(clock), .reset(reset), .enable(enable1), .init(init1),
    .bus(bus1), .state_dbg(state_dbg1)
  );

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic rnd    = 1'b0;

  logic [W-1:0]  exp_q[$];
  logic [LW-1:0] exp_len_q[$];
  byte_t         msg_q[$];

  function automatic int tbl(input int x);
    return (167 * x + 13) % 256;
  endfunction

  function automatic logic [63:0] model_hash(input int nb, input byte_t m[$]);
    logic [63:0] r;
    int h;
    r = '0;
    for (int j = 0; j < nb; j++) begin
      h = j;
      foreach (m[k]) h = tbl(h ^ int'(m[k]));
      r[8*j +: 8] = 8'(h);
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic send_byte(input byte_t d, input logic last, input logic ini,
                           output int waited);
    logic [63:0] full;
    int n;
    @(negedge clock); #1;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last; init = ini;
    if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clock); #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    waited = n;
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
      bus.in_valid = 1'b0; init = 1'b0;
      return;
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; init = 1'b0;
    if (ini) msg_q.delete();
    msg_q.push_back(d);
    if (last) begin
      full = model_hash(HB, msg_q);
      exp_q.push_back(full[W-1:0]);
      exp_len_q.push_back(msg_q.size() > 65535 ? LW'(65535) : LW'(msg_q.size()));
      msg_q.delete();
    end
  endtask

  task automatic drain();
    int n;
    @(negedge clock); #1;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() !== 0 || bus.out_valid !== 1'b0) begin
      $display("FAIL drain: pending=%0d out_valid=%0b, required 0/0", exp_q.size(), bus.out_valid);
    end else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always begin
    @(negedge clock); #2;
    if (bus.out_valid && bus.out_ready && enable && !reset) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: out_hash=%h with no expected hash", bus.out_hash);
      end else begin
        logic [W-1:0] e;
        logic [LW-1:0] el;
        e  = exp_q.pop_front();
        el = exp_len_q.pop_front();
        if (bus.out_hash !== e) $display("FAIL sb_hash: got %h, required %h", bus.out_hash, e);
`ifdef PEARSON_MSG_LEN_EN
        else if (bus.out_len !== el) $display("FAIL sb_len: got %0d, required %0d", bus.out_len, el);
`endif
        else n_pass++;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_hash !== '0 || state_dbg !== START)
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_hash=%h state=%0d, required 0/0/0/START",
               bus.in_ready, bus.out_valid, bus.out_hash, state_dbg);
    else n_pass++;
    #1; reset = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_single_zero();
    int w;
    send_byte(8'h00, 1'b1, 1'b0, w);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_hash !== H_ZERO)
      $display("FAIL single_zero: out_valid=%0b out_hash=%h, required 1/%h", bus.out_valid, bus.out_hash, H_ZERO);
    else n_pass++;
    drain();
  endtask

  task automatic test_two_bytes();
    int w;
    send_byte(8'h01, 1'b0, 1'b0, w);
    n_checks++;
    if (bus.out_valid !== 1'b0 || state_dbg !== ABSORB)
      $display("FAIL two_mid: out_valid=%0b state=%0d, required 0/ABSORB", bus.out_valid, state_dbg);
    else n_pass++;
    send_byte(8'h02, 1'b1, 1'b0, w);
    n_checks++;
    if (bus.out_hash[7:0] !== 8'hC7 || bus.out_hash[15:8] !== 8'hD6)
      $display("FAIL two_bytes: lane0=%h lane1=%h, required C7/D6", bus.out_hash[7:0], bus.out_hash[15:8]);
    else n_pass++;
`ifdef PEARSON_MSG_LEN_EN
    n_checks++;
    if (bus.out_len !== LW'(2)) $display("FAIL two_len: got %0d, required 2", bus.out_len);
    else n_pass++;
`endif
    drain();
  endtask

  task automatic test_backpressure();
    int w;
    logic [W-1:0] held;
    send_byte(8'h01, 1'b1, 1'b0, w);
    held = bus.out_hash;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_hash !== held)
        $display("FAIL bp_hold: in_ready=%0b out_valid=%0b out_hash=%h, required 0/1/%h",
                 bus.in_ready, bus.out_valid, bus.out_hash, held);
      else n_pass++;
    end
    #1; bus.out_ready = 1'b1;
    send_byte(8'h00, 1'b1, 1'b0, w);
    n_checks++;
    if (w !== 0 || bus.out_valid !== 1'b1 || bus.out_hash !== H_ZERO)
      $display("FAIL bp_release: waited=%0d out_valid=%0b out_hash=%h, required 0/1/%h",
               w, bus.out_valid, bus.out_hash, H_ZERO);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    @(negedge clock); #1; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(byte_t'($urandom_range(0, 255)), 1'b1, 1'b0, w);
      n_checks++;
      if (w !== 0 || bus.out_valid !== 1'b1)
        $display("FAIL b2b_%0d: waited=%0d out_valid=%0b, required 0/1", i, w, bus.out_valid);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_init();
    int w;
    send_byte(8'h01, 1'b0, 1'b0, w);
    @(negedge clock); #1; init = 1'b1;
    @(posedge clock); #1; init = 1'b0;
    msg_q.delete();
    n_checks++;
    if (state_dbg !== START) $display("FAIL init_state: state=%0d, required START", state_dbg);
    else n_pass++;
    send_byte(8'h00, 1'b1, 1'b0, w);
    n_checks++;
    if (bus.out_hash !== H_ZERO) $display("FAIL init_abort: got %h, required %h", bus.out_hash, H_ZERO);
    else n_pass++;
    drain();
    send_byte(8'h01, 1'b0, 1'b0, w);
    send_byte(8'h00, 1'b1, 1'b1, w);
    n_checks++;
    if (bus.out_hash !== H_ZERO) $display("FAIL init_with_byte: got %h, required %h", bus.out_hash, H_ZERO);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    send_byte(8'h01, 1'b0, 1'b0, w);
    @(negedge clock); #1; reset = 1'b1;
    @(posedge clock); #1;
    msg_q.delete(); exp_q.delete(); exp_len_q.delete();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_hash !== '0 || state_dbg !== START || bus.in_ready !== 1'b0)
      $display("FAIL reset_mid: out_valid=%0b out_hash=%h state=%0d in_ready=%0b, required 0/0/START/0",
               bus.out_valid, bus.out_hash, state_dbg, bus.in_ready);
    else n_pass++;
    @(negedge clock); #1; reset = 1'b0;
    send_byte(8'h00, 1'b1, 1'b0, w);
    n_checks++;
    if (bus.out_hash !== H_ZERO) $display("FAIL reset_recover: got %h, required %h", bus.out_hash, H_ZERO);
    else n_pass++;
    drain();
  endtask

  task automatic test_enable();
    int w;
    logic [W-1:0] held;
    send_byte(8'h00, 1'b1, 1'b0, w);
    held = bus.out_hash;
    @(negedge clock); #1;
    enable = 1'b0; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'h05; bus.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_hash !== held || state_dbg !== START)
        $display("FAIL enable_hold: in_ready=%0b out_valid=%0b out_hash=%h state=%0d, required 0/1/%h/START",
                 bus.in_ready, bus.out_valid, bus.out_hash, state_dbg, held);
      else n_pass++;
    end
    bus.in_valid = 1'b0; enable = 1'b1;
    drain();
  endtask

  task automatic test_random();
    int w, len;
    rnd = 1'b1;
    for (int m = 0; m < 12; m++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        send_byte(byte_t'($urandom_range(0, 255)), k == len - 1,
                  (k > 0) && ($urandom_range(0, 7) == 0), w);
    end
    rnd = 1'b0;
    drain();
  endtask

  task automatic test_one_lane();
    logic [63:0] full;
    byte_t m1[$];
    int n;
    for (int i = 0; i < 5; i++) begin
      byte_t d;
      d = (i == 0) ? 8'h00 : byte_t'($urandom_range(0, 255));
      m1.delete(); m1.push_back(d);
      full = model_hash(1, m1);
      @(negedge clock); #1;
      bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_last = 1'b1; bus1.out_ready = 1'b1;
      #1; n = 0;
      while (!bus1.in_ready && n < 20) begin @(negedge clock); #1; n++; end
      @(posedge clock); #1;
      bus1.in_valid = 1'b0;
      n_checks++;
      if (bus1.out_valid !== 1'b1 || bus1.out_hash !== full[7:0] || (i == 0 && bus1.out_hash !== 8'h0D))
        $display("FAIL one_lane_%0d: out_valid=%0b out_hash=%h, required 1/%h", i, bus1.out_valid,
                 bus1.out_hash, full[7:0]);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; init = 1'b0;
    enable1 = 1'b1; init1 = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0; bus1.out_ready = 1'b0;
    test_reset();
    test_single_zero();
    test_two_bytes();
    test_backpressure();
    test_back_to_back();
    test_init();
    test_reset_mid();
    test_enable();
    test_random();
    test_one_lane();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
